// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 16x-oversampled UART receiver (start, DBIT data LSB first,
// optional even parity, SB_TICK/16 stop bits).
// Optional feature macro: UART_RX_PARITY_EN. When defined, a PARITY state is
// inserted between DATA and STOP and parity_err reports an even-parity
// mismatch. When undefined, parity_err is tied low. The port list is the same
// in both builds.
module uart_rx_16x #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    // Tick counts: middle of the start bit, end of a 16-tick bit, end of stop.
    localparam logic [4:0] S_MID  = 5'd7;
    localparam logic [4:0] S_LAST = 5'd15;
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [3:0] N_LAST = 4'(DBIT - 1);

    logic            rx_meta_q, rx_s_q;
    logic [2:0]      state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [3:0]      n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM: next-state, counters, shift register and output capture.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                // Falling edge is acted on immediately, tick or not.
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = 5'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = 5'd0;
                            n_d     = 4'd0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = 5'd0;
                        shift_d = {rx_s_q, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        par_d   = rx_s_q;
                        s_d     = 5'd0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        // Deliver the word even on a bad stop bit; flag it instead.
                        state_d = IDLE;
                        dout_d  = shift_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^shift_q) ^ par_q;
`endif
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 5'd0;
            n_q     <= 4'd0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: stimulus pushes expected words, a monitor
// pops and compares on every rx_done_tick. Tick divider shortened for runtime.
module tb_uart_rx_16x;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int TICK_DIV = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            s_tick = 1'b0;
    logic            rx = 1'b1;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick, frame_err, parity_err, busy;

    uart_rx_16x #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
        .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #10 clk = ~clk;

    int div_cnt = 0;
    int tick_total = 0;
    always @(posedge clk) begin
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt <= 0;
            s_tick  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1;
            s_tick  <= 1'b0;
        end
        if (s_tick) tick_total <= tick_total + 1;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop on every done pulse; between pulses outputs must hold.
    logic [7:0] hold_d = '0;
    logic       hold_fe = 1'b0, hold_pe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_d  = '0;
            hold_fe = 1'b0;
            hold_pe = 1'b0;
        end else if (rx_done_tick) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("rx word %02h fe=%0b pe=%0b (expected %02h fe=%0b pe=%0b)",
                         dout, frame_err, parity_err, e.d, e.fe, e.pe);
                chk("dout", 32'(dout), 32'(e.d));
                chk("frame_err", 32'(frame_err), 32'(e.fe));
                chk("parity_err", 32'(parity_err), 32'(e.pe));
                hold_d  = e.d;
                hold_fe = e.fe;
                hold_pe = e.pe;
            end
        end else if (s_tick) begin
            chk("dout_hold", 32'(dout), 32'(hold_d));
            chk("frame_err_hold", 32'(frame_err), 32'(hold_fe));
            chk("parity_err_hold", 32'(parity_err), 32'(hold_pe));
        end
    end

    task automatic wait_ticks(input int n);
        int target;
        target = tick_total + n;
        while (tick_total < target) @(negedge clk);
    endtask

    // Drive one frame; ferr holds the stop bit low, bad_par inverts parity.
    task automatic send_frame(input logic [7:0] d, input bit ferr, input bit bad_par);
        exp_t e;
        e.d  = d;
        e.fe = ferr;
`ifdef UART_RX_PARITY_EN
        e.pe = bad_par;
`else
        e.pe = 1'b0;
`endif
        exp_q.push_back(e);
        pushed++;
        $display("tx word %02h ferr=%0b bad_par=%0b", d, ferr, bad_par);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < DBIT; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ bad_par;
        wait_ticks(16);
`endif
        if (ferr) begin
            rx = 1'b0;
            wait_ticks(12);
            rx = 1'b1;
            wait_ticks(14);
        end else begin
            rx = 1'b1;
            wait_ticks(SB_TICK);
        end
    endtask

    initial begin
        int guard;
        // Reset with idle line.
        reset = 1'b1;
        rx    = 1'b1;
        #100;
        @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_done", 32'(rx_done_tick), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_ticks(40);
        chk("idle_busy", 32'(busy), 32'd0);

        // Back-to-back normal frames.
        send_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0);
        wait_ticks(8);
        chk("three_pulses", 32'(done_cnt), 32'd3);

        // Glitch: short low pulse must be rejected.
        rx = 1'b0;
        wait_ticks(2);
        chk("glitch_busy_high", 32'(busy), 32'd1);
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(10);
        chk("glitch_busy_low", 32'(busy), 32'd0);
        chk("glitch_no_pulse", 32'(done_cnt), 32'd3);

        // Framing error followed by a good frame.
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0);

        // Reset after the 4th data bit of 0xFF.
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(64);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_done", 32'(rx_done_tick), 32'd0);
        reset = 1'b0;
        wait_ticks(20);
        send_frame(8'h12, 1'b0, 1'b0);

        // Parity frames (bad_par only affects the parity build).
        send_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1);

        // Randomized frames with random errors and idle gaps.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            bit fe, bp;
            d  = 8'($urandom);
            fe = ($urandom_range(0, 3) == 0);
            bp = ($urandom_range(0, 2) == 0);
            send_frame(d, fe, bp);
            wait_ticks($urandom_range(0, 5));
        end

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        wait_ticks(4);
        chk("pulse_count", 32'(done_cnt), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
